pasc_port_arbiter: RTL

Shares the single PASC shared-memory port (`axi_we` / `axi_addr` / `axi_data` / `axi_q`) between an independent write requester and read requester. It replaces the combinational `we ? waddr : raddr` mux with round-robin arbitration, a single-outstanding-transaction FSM, address range checking and valid/ready response channels. It sits between the AXI-lite slave unit interface and the `pasc` instance.

---
 rtl/pasc_arb_pkg.sv | 27 ++
 rtl/pasc_rr_arb2.sv | 42 ++++
 rtl/pasc_port_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pasc_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pasc_arb_pkg
// Description : Shared types and constants for the PASC port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package pasc_arb_pkg;

    // Transaction FSM states, at most one transaction in flight
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_READ    = 3'd2,
        ST_WR_RESP = 3'd3,
        ST_RD_RESP = 3'd4
    } arb_state_t;

    // Default valid address window: [PASC_ADDR_LO, PASC_ADDR_HI)
    localparam logic [15:0] PASC_ADDR_LO = 16'h4000;
    localparam logic [15:0] PASC_ADDR_HI = 16'hFC00;

    // Bit positions inside the two-bit request / grant vectors
    localparam int GRANT_WR = 0;
    localparam int GRANT_RD = 1;

endpackage
`default_nettype wire

// File: rtl/pasc_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : pasc_rr_arb2
// Description : Two-way round-robin arbiter. A lone requester always wins;
//               on a tie the side not granted last wins. The history bit
//               only moves when the caller actually takes a request.
// Revision    : 1.0 - initial release
// ============================================================================
module pasc_rr_arb2
    import pasc_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    // 1 = read side was served last; resets to read so write wins first tie
    logic r_last_rd;

    // One-hot grant: lone requester wins, tie goes to the side not served last
    always_comb begin
        grant = 2'b00;
        if (req[GRANT_WR] && (!req[GRANT_RD] || r_last_rd)) begin
            grant[GRANT_WR] = 1'b1;
        end else if (req[GRANT_RD]) begin
            grant[GRANT_RD] = 1'b1;
        end
    end

    // Record who was served, only when a request is really taken
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_rd <= 1'b1;
        end else if (accept && (grant != 2'b00)) begin
            r_last_rd <= grant[GRANT_RD];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pasc_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pasc_port_arbiter
// Description : Shares the single PASC memory port between a write and a read
//               requester. Round-robin arbitration, one outstanding
//               transaction, address window check, valid/ready responses.
// Revision    : 1.0 - initial release
// ============================================================================
module pasc_port_arbiter
    import pasc_arb_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    READ_LATENCY = 1,
    parameter logic [ADDR_WIDTH-1:0] ADDR_LO      = ADDR_WIDTH'(PASC_ADDR_LO),
    parameter logic [ADDR_WIDTH-1:0] ADDR_HI      = ADDR_WIDTH'(PASC_ADDR_HI)
) (
    input  logic                  clk,
    input  logic                  reset,
    // write request / response
    input  logic                  wr_req_valid,
    output logic                  wr_req_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_resp_valid,
    output logic                  wr_resp_err,
    input  logic                  wr_resp_ready,
    // read request / response
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_resp_valid,
    output logic [DATA_WIDTH-1:0] rd_resp_data,
    output logic                  rd_resp_err,
    input  logic                  rd_resp_ready,
    // PASC port
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    // Wait states left before mem_q is valid (READ_LATENCY is 1..3)
    localparam logic [1:0] c_lat_init = 2'(READ_LATENCY - 1);

    arb_state_t r_state;
    logic [1:0] r_lat_cnt;

    logic [1:0] w_req;
    logic [1:0] w_grant;
    logic       w_idle;
    logic       w_wr_in_range;
    logic       w_rd_in_range;

    assign w_idle            = (r_state == ST_IDLE);
    assign w_req[GRANT_WR]   = wr_req_valid;
    assign w_req[GRANT_RD]   = rd_req_valid;
    assign wr_req_ready      = w_idle && w_grant[GRANT_WR];
    assign rd_req_ready      = w_idle && w_grant[GRANT_RD];
    assign w_wr_in_range     = (wr_addr >= ADDR_LO) && (wr_addr < ADDR_HI);
    assign w_rd_in_range     = (rd_addr >= ADDR_LO) && (rd_addr < ADDR_HI);

    pasc_rr_arb2 u_rr_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (w_req),
        .accept (w_idle),
        .grant  (w_grant)
    );

    // Transaction FSM; every PASC-port and response output is registered here
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_lat_cnt     <= 2'd0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_data      <= '0;
            wr_resp_valid <= 1'b0;
            wr_resp_err   <= 1'b0;
            rd_resp_valid <= 1'b0;
            rd_resp_err   <= 1'b0;
            rd_resp_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant[GRANT_WR]) begin
                        mem_addr <= wr_addr;
                        mem_data <= wr_data;
                        if (w_wr_in_range) begin
                            mem_we  <= 1'b1;
                            r_state <= ST_WRITE;
                        end else begin
                            // Out of window: answer with an error, never touch memory
                            wr_resp_valid <= 1'b1;
                            wr_resp_err   <= 1'b1;
                            r_state       <= ST_WR_RESP;
                        end
                    end else if (w_grant[GRANT_RD]) begin
                        mem_addr <= rd_addr;
                        mem_data <= '0;
                        if (w_rd_in_range) begin
                            r_lat_cnt <= c_lat_init;
                            r_state   <= ST_READ;
                        end else begin
                            rd_resp_valid <= 1'b1;
                            rd_resp_err   <= 1'b1;
                            rd_resp_data  <= '0;
                            r_state       <= ST_RD_RESP;
                        end
                    end
                end
                ST_WRITE: begin
                    // Single-cycle write strobe, then report success
                    mem_we        <= 1'b0;
                    wr_resp_valid <= 1'b1;
                    wr_resp_err   <= 1'b0;
                    r_state       <= ST_WR_RESP;
                end
                ST_READ: begin
                    // Address is held; capture mem_q once the latency has elapsed
                    if (r_lat_cnt != 2'd0) begin
                        r_lat_cnt <= r_lat_cnt - 2'd1;
                    end else begin
                        rd_resp_data  <= mem_q;
                        rd_resp_valid <= 1'b1;
                        rd_resp_err   <= 1'b0;
                        r_state       <= ST_RD_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (wr_resp_ready) begin
                        wr_resp_valid <= 1'b0;
                        wr_resp_err   <= 1'b0;
                        mem_addr      <= '0;
                        mem_data      <= '0;
                        r_state       <= ST_IDLE;
                    end
                end
                ST_RD_RESP: begin
                    if (rd_resp_ready) begin
                        rd_resp_valid <= 1'b0;
                        rd_resp_err   <= 1'b0;
                        rd_resp_data  <= '0;
                        mem_addr      <= '0;
                        mem_data      <= '0;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
